// File: rtl/fpu_arbiter.sv
// Round-robin sequencer sharing one combinational fpu among N_REQ requesters.
// One operation in flight: accept, hold operands LAT cycles, capture, respond.
module fpu_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 2,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_opd1,
    input  logic [32*N_REQ-1:0]  req_opd2,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [31:0]          fpu_opd1,
    output logic [31:0]          fpu_opd2,
    output logic [1:0]           fpu_op,
    input  logic [31:0]          fpu_res,
    input  logic [3:0]           fpu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_res,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           accept;
    logic [CW-1:0]  cnt;

    // Round-robin pick: scan far-to-near so the nearest requester after last_grant wins.
    always_comb begin : arb
        int unsigned idx;
        winner  = last_grant;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (req_valid[idx]) begin
                winner  = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : fsm_state
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Grant is combinational in IDLE; suppressed while reset is asserted.
    always_comb begin : fsm_next
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req && !rst) begin
                    accept    = 1'b1;
                    req_ready = N_REQ'(1) << winner;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin : datapath
        if (rst) begin
            last_grant <= IDW'(N_REQ - 1);
            cnt        <= '0;
            fpu_opd1   <= '0;
            fpu_opd2   <= '0;
            fpu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_res    <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fpu_opd1   <= req_opd1[32*winner +: 32];
                        fpu_opd2   <= req_opd2[32*winner +: 32];
                        fpu_op     <= req_op[2*winner +: 2];
                        rsp_id     <= winner;
                        last_grant <= winner;
                        cnt        <= CW'(LAT - 1);
                    end
                end
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_res   <= fpu_res;
                        rsp_flags <= fpu_flags;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Sequencer and round-robin arbiter that shares the single combinational `fpu` datapath (add/sub/mul/div) between `N_REQ` requesters. It accepts one operation at a time through a valid/ready request port and drives registered operands and op to the `fpu` for `LAT` cycles so the combinational result settles. It then captures the result and flags, and returns them, tagged with the requester ID, through a valid/ready response port. It sits between the requesting engines and the `fpu` instance.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `LAT`, 2: cycles the `fpu` inputs are held before the result is sampled, ≥1.
- `IDW`, $clog2(N_REQ): requester ID width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: one-hot grant/accept, at most one bit set.
- `req_opd1` in 32*N_REQ: packed operand 1; requester i uses bits [32i+31:32i].
- `req_opd2` in 32*N_REQ: packed operand 2, same packing.
- `req_op` in 2*N_REQ: packed op codes (00 add, 01 sub, 10 mul, 11 div).
- `fpu_opd1`, `fpu_opd2` out 32: registered operands to the `fpu`.
- `fpu_op` out 2: registered op to the `fpu`.
- `fpu_res` in 32: `fpu` result.
- `fpu_flags` in 4: {exp_overflow, exp_underflow, nan, zero} from the `fpu`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out IDW: index of the requester that issued the operation.
- `rsp_res` out 32: captured result.
- `rsp_flags` out 4: captured flags, same bit order as `fpu_flags`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, select the winner round-robin: search from `last_grant+1` upward, wrapping modulo N_REQ.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On the clock edge: load `fpu_opd1`, `fpu_opd2` and `fpu_op` from the winner's slice, load `rsp_id` with the winner index, set `last_grant` to the winner, load the counter with LAT-1, and go to EXEC.
  - If no `req_valid` is high, stay in IDLE with all `req_ready` bits at 0.
- **EXEC**
  - `fpu_*` registers are held constant.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `fpu_res` into `rsp_res` and `fpu_flags` into `rsp_flags`, set `rsp_valid`, and go to RESP.
- **RESP**
  - `rsp_*` outputs are held stable while `rsp_valid` is high.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid` and go to IDLE.
  - No new request is accepted in the response handshake cycle.
- `req_ready` is all-zero in EXEC and RESP regardless of `req_valid`.
- Requester rules:
  - A requester keeps `req_valid` and its payload stable until accepted.
  - A requester may deassert `req_valid` before acceptance. The block does not depend on this, because the grant is combinational within the same cycle.
- The `fpu_*` registers retain their last values in IDLE and RESP.
- Reset values:
  - FSM = IDLE.
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0.
  - `rsp_id` = 0, `rsp_res` = 0, `rsp_flags` = 0.
  - `fpu_opd1` = 0, `fpu_opd2` = 0, `fpu_op` = 0.
  - `last_grant` = N_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded with no response, and all registers take their reset values immediately.

## Timing
- Request accepted in cycle t (`req_valid[i] & req_ready[i]`).
- `fpu_*` inputs are valid in cycles t+1 through t+LAT.
- Result is sampled at the end of cycle t+LAT.
- `rsp_valid` rises in cycle t+LAT+1.
- With `rsp_ready` held high, the response handshake occurs in cycle t+LAT+1, and the earliest next `req_ready` is in cycle t+LAT+2.
- Peak throughput is 1 operation per LAT+2 cycles.
- `busy` is high from cycle t+1 through the response handshake cycle.
- Back-pressure: with `rsp_ready` low, RESP is held indefinitely and no grant is issued.

## Test plan
- Requester 0: 0x3F800000 + 0x40000000, op 00 → after LAT+1 cycles, `rsp_valid`=1, `rsp_res`=0x40400000, `rsp_id`=0, `rsp_flags`=0000.
- Requester 2: 0x40400000 − 0x40400000, op 01 → `rsp_res` is +0 or −0 (exponent and mantissa all zero), zero flag (`rsp_flags[0]`)=1, `rsp_id`=2. Requester 1: 0x40000000 × 0x40400000, op 10 → `rsp_res`=0x40C00000.
- All four requesters hold `req_valid` high, each with distinct operands → grant order 0,1,2,3,0,1; `rsp_id` sequence matches; accepts are exactly LAT+2 cycles apart; `req_ready` is never multi-hot.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0 throughout; accept occurs in the cycle after `rsp_ready` rises.
- `rst` pulsed during EXEC → `busy`, `rsp_valid` and `req_ready` drop asynchronously, and no response is produced. The next request, from requester 3 only, is granted: `req_ready`=4'b1000, `rsp_id`=3.
- LAT=1 build: 0x40C00000 / 0x40000000, op 11 → `rsp_res`=0x40400000, with `rsp_valid` in cycle t+2.
